// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: next-PC selects, FSM states, reset PC.
package pc_sequencer_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PCSEL_W = 2;

    localparam logic [PCSEL_W-1:0] PCSEL_PC4  = 2'b00;
    localparam logic [PCSEL_W-1:0] PCSEL_BR   = 2'b01;
    localparam logic [PCSEL_W-1:0] PCSEL_JAL  = 2'b10;
    localparam logic [PCSEL_W-1:0] PCSEL_JALR = 2'b11;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h4000_0000;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'b00,
        ST_RUN    = 2'b01,
        ST_BUBBLE = 2'b10,
        ST_HALT   = 2'b11
    } pc_state_e;

    // Any valid execute-stage select other than PC+4 changes control flow.
    function automatic logic is_taken(input logic valid, input logic [PCSEL_W-1:0] sel);
        return valid && (sel != PCSEL_PC4);
    endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Redirect target selection; JALR bit 0 is cleared and non-word-aligned targets are flagged.
module pc_target_mux
    import pc_sequencer_pkg::*;
(
    input  logic [PCSEL_W-1:0] pc_sel_i,
    input  logic [XLEN-1:0]    alu_target_i,
    input  logic [XLEN-1:0]    jal_target_i,
    input  logic [XLEN-1:0]    jalr_target_i,
    output logic [XLEN-1:0]    target_c_o,
    output logic               misalign_c_o
);

    always_comb begin
        target_c_o = '0;
        unique case (pc_sel_i)
            PCSEL_BR:   target_c_o = alu_target_i;
            PCSEL_JAL:  target_c_o = jal_target_i;
            PCSEL_JALR: target_c_o = {jalr_target_i[XLEN-1:1], 1'b0};
            default:    target_c_o = '0;
        endcase
        misalign_c_o = (target_c_o[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural fetch PC owner: sequences IMEM requests and applies stall, redirect and trap policy.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [PCSEL_W-1:0] pc_sel,
    input  logic [XLEN-1:0]    alu_target,
    input  logic [XLEN-1:0]    jal_target,
    input  logic [XLEN-1:0]    jalr_target,
    input  logic               stall,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_ready,
    output logic               fetch_valid,
    output logic [XLEN-1:0]    fetch_pc,
    output logic               flush,
    output logic               misalign_exc,
    output logic [CNT_W-1:0]   redirect_cnt
);

    pc_state_e        state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0]  target;
    logic             target_misalign;
    logic             taken;

    pc_target_mux u_target_mux (
        .pc_sel_i      (pc_sel),
        .alu_target_i  (alu_target),
        .jal_target_i  (jal_target),
        .jalr_target_i (jalr_target),
        .target_c_o    (target),
        .misalign_c_o  (target_misalign)
    );

    assign taken = is_taken(redirect_valid, pc_sel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            misalign_q    <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            misalign_q    <= misalign_d;
            cnt_q         <= cnt_d;
        end
    end

    // Redirects are honoured in RUN and BUBBLE and take priority over stall and the handshake.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        fetch_pc_d    = fetch_pc_q;
        misalign_d    = misalign_q;
        cnt_d         = cnt_q;
        imem_req      = 1'b0;
        flush         = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                fetch_valid_d = 1'b0;
                state_d       = ST_RUN;
            end
            ST_RUN, ST_BUBBLE: begin
                imem_req = (state_q == ST_RUN) && !stall;
                if (taken) begin
                    flush         = 1'b1;
                    fetch_valid_d = 1'b0;
                    if (target_misalign) begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        pc_d    = target;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ST_BUBBLE;
                    end
                end else if (state_q == ST_BUBBLE) begin
                    fetch_valid_d = 1'b0;
                    state_d       = ST_RUN;
                end else if (!stall) begin
                    if (imem_ready) begin
                        pc_d          = pc_q + XLEN'(4);
                        fetch_valid_d = 1'b1;
                        fetch_pc_d    = pc_q;
                    end else begin
                        fetch_valid_d = 1'b0;
                    end
                end
            end
            ST_HALT: begin
                fetch_valid_d = 1'b0;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    assign imem_addr    = pc_q;
    assign fetch_valid  = fetch_valid_q;
    assign fetch_pc     = fetch_pc_q;
    assign misalign_exc = misalign_q;
    assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: cycle model with per-cycle compare plus directed literal checkpoints.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [1:0]  pc_sel;
    logic [31:0] alu_target, jal_target, jalr_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        flush;
    logic        misalign_exc;
    logic [31:0] redirect_cnt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .pc_sel         (pc_sel),
        .alu_target     (alu_target),
        .jal_target     (jal_target),
        .jalr_target    (jalr_target),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .flush          (flush),
        .misalign_exc   (misalign_exc),
        .redirect_cnt   (redirect_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks dead cycles, the trap flag and the fetch stream.
    bit          m_boot, m_dead, m_halt, m_fv, m_mis;
    logic [31:0] m_pc, m_fpc, m_cnt;

    function automatic logic [31:0] spec_target(input logic [1:0] sel);
        case (sel)
            2'd1:    return alu_target;
            2'd2:    return jal_target;
            2'd3:    return jalr_target & 32'hFFFF_FFFE;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [31:0] t;
        if (rst) begin
            m_boot = 1'b1; m_dead = 1'b0; m_halt = 1'b0; m_fv = 1'b0; m_mis = 1'b0;
            m_pc = RST_PC; m_fpc = RST_PC; m_cnt = 32'h0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (!m_halt) begin
            t = spec_target(pc_sel);
            if (redirect_valid && pc_sel != 2'd0) begin
                m_fv = 1'b0;
                if (t % 4 != 0) begin
                    m_halt = 1'b1;
                    m_mis  = 1'b1;
                end else begin
                    m_pc   = t;
                    m_cnt  = m_cnt + 1;
                    m_dead = 1'b1;
                end
            end else if (m_dead) begin
                m_dead = 1'b0;
                m_fv   = 1'b0;
            end else if (!stall) begin
                m_fv = imem_ready;
                if (imem_ready) begin
                    m_fpc = m_pc;
                    m_pc  = m_pc + 4;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic exp_req, exp_flush;
        exp_req   = !rst && !m_boot && !m_dead && !m_halt && !stall;
        exp_flush = !rst && !m_boot && !m_halt && redirect_valid && (pc_sel != 2'd0);
        chk("m_req",   32'(imem_req),     32'(exp_req));
        chk("m_flush", 32'(flush),        32'(exp_flush));
        chk("m_fv",    32'(fetch_valid),  32'(m_fv));
        chk("m_mis",   32'(misalign_exc), 32'(m_mis));
        chk("m_cnt",   redirect_cnt,      m_cnt);
        if (exp_req) chk("m_addr", imem_addr, m_pc);
        if (m_fv)    chk("m_fpc",  fetch_pc,  m_fpc);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    task automatic idle_inputs();
        redirect_valid = 1'b0; pc_sel = 2'd0; stall = 1'b0; imem_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        alu_target = 32'h0; jal_target = 32'h0; jalr_target = 32'h0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req",  32'(imem_req),     32'h0);
        chk("rst_fv",   32'(fetch_valid),  32'h0);
        chk("rst_fpc",  fetch_pc,          RST_PC);
        chk("rst_addr", imem_addr,         RST_PC);
        chk("rst_mis",  32'(misalign_exc), 32'h0);
        chk("rst_cnt",  redirect_cnt,      32'h0);

        // Reset release and sequential fetch.
        rst = 1'b0;
        at_neg(); chk("boot_req", 32'(imem_req), 32'h0);
        tick(); at_neg();
        chk("c1_req", 32'(imem_req), 32'h1);
        chk("c1_addr", imem_addr, 32'h4000_0000);
        chk("c1_fv", 32'(fetch_valid), 32'h0);
        tick(); at_neg();
        chk("c2_addr", imem_addr, 32'h4000_0004);
        chk("c2_fv", 32'(fetch_valid), 32'h1);
        chk("c2_fpc", fetch_pc, 32'h4000_0000);

        // IMEM not ready: address held, then JAL redirect withdraws the request.
        tick(); imem_ready = 1'b0; at_neg();
        chk("c3_addr", imem_addr, 32'h4000_0008);
        chk("c3_fpc", fetch_pc, 32'h4000_0004);
        tick(); at_neg();
        chk("c4_addr", imem_addr, 32'h4000_0008);
        chk("c4_fv", 32'(fetch_valid), 32'h0);
        tick(); redirect_valid = 1'b1; pc_sel = 2'd2; jal_target = 32'h4000_0040; at_neg();
        chk("c5_addr", imem_addr, 32'h4000_0008);
        chk("c5_flush", 32'(flush), 32'h1);
        tick(); idle_inputs(); at_neg();
        chk("c6_req", 32'(imem_req), 32'h0);
        chk("c6_cnt", redirect_cnt, 32'h1);
        tick(); at_neg();
        chk("c7_addr", imem_addr, 32'h4000_0040);
        tick(); at_neg();
        chk("c8_fpc", fetch_pc, 32'h4000_0040);

        // Taken branch with the IMEM accepting in the redirect cycle.
        tick(); redirect_valid = 1'b1; pc_sel = 2'd1; alu_target = 32'h4000_0100; at_neg();
        chk("c9_addr", imem_addr, 32'h4000_0048);
        chk("c9_flush", 32'(flush), 32'h1);
        tick(); idle_inputs(); at_neg();
        chk("c10_req", 32'(imem_req), 32'h0);
        chk("c10_fv", 32'(fetch_valid), 32'h0);
        chk("c10_cnt", redirect_cnt, 32'h2);
        tick(); at_neg();
        chk("c11_addr", imem_addr, 32'h4000_0100);
        chk("c11_fv", 32'(fetch_valid), 32'h0);

        // Stall for three cycles; decode keeps seeing the same word.
        tick(); stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("stall_req", 32'(imem_req), 32'h0);
            chk("stall_fv", 32'(fetch_valid), 32'h1);
            chk("stall_fpc", fetch_pc, 32'h4000_0100);
            tick();
        end
        stall = 1'b0; at_neg();
        chk("c15_addr", imem_addr, 32'h4000_0104);
        chk("c15_fpc", fetch_pc, 32'h4000_0100);
        tick(); at_neg();
        chk("c16_addr", imem_addr, 32'h4000_0108);

        // Address wrap at the top of the 32-bit space.
        redirect_valid = 1'b1; pc_sel = 2'd2; jal_target = 32'hFFFF_FFFC;
        tick(); idle_inputs(); at_neg();
        chk("c17_cnt", redirect_cnt, 32'h3);
        tick(); at_neg();
        chk("c18_addr", imem_addr, 32'hFFFF_FFFC);
        tick(); redirect_valid = 1'b1; pc_sel = 2'd2; jal_target = 32'h4000_0080; at_neg();
        chk("c19_addr", imem_addr, 32'h0000_0000);
        chk("c19_fpc", fetch_pc, 32'hFFFF_FFFC);

        // Asynchronous reset in the middle of a bubble.
        tick(); idle_inputs(); #2; rst = 1'b1; #1;
        chk("arst_addr", imem_addr, RST_PC);
        chk("arst_cnt", redirect_cnt, 32'h0);
        chk("arst_fpc", fetch_pc, RST_PC);
        chk("arst_fv", 32'(fetch_valid), 32'h0);
        tick(); rst = 1'b0;
        tick(); at_neg();
        chk("rel_addr", imem_addr, RST_PC);

        // Mixed traffic with word-aligned targets, checked by the model every cycle.
        for (int i = 0; i < 300; i++) begin
            tick();
            stall          = ($urandom_range(0, 3) == 0);
            imem_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 5) == 0);
            pc_sel         = 2'($urandom_range(0, 3));
            alu_target     = $urandom() & 32'hFFFF_FFFC;
            jal_target     = $urandom() & 32'hFFFF_FFFC;
            jalr_target    = $urandom() & 32'hFFFF_FFFD;
        end

        // Misaligned JALR target traps until reset.
        tick(); idle_inputs(); rst = 1'b1;
        tick(); rst = 1'b0;
        tick(); tick(); redirect_valid = 1'b1; pc_sel = 2'd3; jalr_target = 32'h4000_0203; at_neg();
        chk("mis_addr", imem_addr, 32'h4000_0004);
        chk("mis_flush", 32'(flush), 32'h1);
        chk("mis_pre", 32'(misalign_exc), 32'h0);
        tick(); idle_inputs(); at_neg();
        chk("mis_exc", 32'(misalign_exc), 32'h1);
        chk("mis_req", 32'(imem_req), 32'h0);
        chk("mis_fv", 32'(fetch_valid), 32'h0);
        chk("mis_cnt", redirect_cnt, 32'h0);
        for (int i = 0; i < 20; i++) begin
            tick();
            redirect_valid = 1'(i % 2);
            pc_sel = 2'd1;
            alu_target = 32'h4000_1000;
        end
        at_neg();
        chk("halt_req", 32'(imem_req), 32'h0);
        chk("halt_flush", 32'(flush), 32'h0);
        chk("halt_exc", 32'(misalign_exc), 32'h1);
        tick(); idle_inputs(); rst = 1'b1; #1;
        chk("clr_exc", 32'(misalign_exc), 32'h0);
        tick(); rst = 1'b0;
        tick(); at_neg();
        chk("post_addr", imem_addr, RST_PC);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural fetch PC of the RV32I core and sequences instruction-memory requests.
- Consumes the 2-bit next-PC select produced by the execute-stage PC select decoder, plus the three candidate targets.
- Applies stall, redirect, flush and misaligned-target trap policy.
- Sits between the execute stage and the instruction memory (IMEM); drives fetch address and fetch-valid into decode.

Parameters:
- RESET_PC, 32'h4000_0000, first fetch address after reset.
- CNT_W, 32, width of the taken-redirect performance counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  execute-stage instruction is valid and pc_sel is meaningful.
- pc_sel  in  2  next-PC select: 00 = PC+4, 01 = branch target (alu_target), 10 = jal_target, 11 = jalr_target.
- alu_target  in  32  branch target from ALU.
- jal_target  in  32  PC+imm for JAL.
- jalr_target  in  32  rs1+imm for JALR; bit 0 is cleared internally before use.
- stall  in  1  decode hazard stall; freezes fetch.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, word aligned.
- imem_ready  in  1  IMEM accepts request this cycle; data is returned exactly 1 cycle later.
- fetch_valid  out  1  instruction word presented to decode this cycle is valid.
- fetch_pc  out  32  PC of that instruction.
- flush  out  1  kill the younger instruction currently in decode.
- misalign_exc  out  1  sticky: redirect target not 4-byte aligned.
- redirect_cnt  out  CNT_W  count of taken redirects.

Behaviour:
- Reset (async, rst=1):
  - Outputs: pc_q=RESET_PC, state=BOOT, imem_req=0, fetch_valid=0, flush=0, misalign_exc=0, redirect_cnt=0, fetch_pc=RESET_PC.
  - Reset asserted mid-request abandons the request; nothing is replayed.
- States:
  - BOOT: imem_req=0 for exactly one cycle after rst deasserts, then go to RUN.
  - RUN: normal fetch.
  - BUBBLE: one dead cycle after a taken redirect; imem_req=0; then go to RUN.
  - HALT: misaligned target; imem_req=0 and fetch_valid=0 forever until reset.
- Taken redirect: redirect_valid=1 and pc_sel!=00. It has priority over stall and imem_ready.
  - target = mux(pc_sel).
  - If target[1:0]!=00: go to HALT, set misalign_exc=1, flush=1 this cycle; redirect_cnt unchanged.
  - Otherwise:
    - flush=1 combinationally in the same cycle.
    - pc_q<=target; any accepted-but-unreturned fetch is squashed (fetch_valid=0 next cycle).
    - redirect_cnt increments, wrapping mod 2^CNT_W.
    - Go to BUBBLE.
  - Net penalty: the first target fetch is issued 2 cycles after the redirect cycle.
- Not-taken (pc_sel=00) or redirect_valid=0: no flush; fetch proceeds.
- RUN:
  - imem_req=!stall; imem_addr=pc_q.
  - On imem_req&&imem_ready: pc_q<=pc_q+4 (wraps mod 2^32). Next cycle fetch_valid=1 and fetch_pc=the accepted address.
  - If no acceptance: fetch_valid=0 next cycle.
- Handshake: while imem_req&&!imem_ready, imem_addr is held stable. The request may only be withdrawn by a stall rising, a taken redirect, or reset.
- Stall: pc_q holds. fetch_valid/fetch_pc are held for as long as stall=1, so decode re-sees the same word; the IMEM output is not re-registered.
- Redirect arriving while stalled: redirect wins; stall is ignored that cycle.
- flush is purely combinational from redirect_valid, pc_sel and state; flush=0 in BOOT and HALT.
- All other outputs are registered.

Decomposition:
- Shared package/header, alongside Opcode.vh, holds:
  - PCSEL_PC4=2'b00, PCSEL_BR=2'b01, PCSEL_JAL=2'b10, PCSEL_JALR=2'b11.
  - State encodings BOOT/RUN/BUBBLE/HALT.
  - RESET_PC default.
- One natural sub-module: pc_target_mux. Combinational; selects the target, clears jalr bit 0, and flags misalignment. The FSM, PC register and counter stay in pc_sequencer.

Test Plan:
1. Reset release, imem_ready=1: cycle 0 req=0; cycle 1 addr=0x4000_0000; subsequent addrs 0x4000_0004, 0x4000_0008. fetch_valid rises one cycle after the first accept, with fetch_pc=0x4000_0000.
2. Taken branch: pc_sel=01, alu_target=0x4000_0100, redirect_valid=1. Expect flush=1 that cycle, next cycle req=0 (BUBBLE), then addr=0x4000_0100. redirect_cnt=1; fetch_valid=0 for 2 cycles.
3. jalr_target=0x4000_0203 with pc_sel=11. Expect bit 0 cleared → 0x4000_0202, misaligned: misalign_exc=1, HALT. imem_req stays 0 for 20 cycles; cleared only by rst.
4. stall=1 for 3 cycles at pc_q=0x4000_0010. Expect req=0, fetch_pc/fetch_valid held. On release addr=0x4000_0010, no PC skipped.
5. imem_ready=0 for 2 cycles. Expect addr held at 0x4000_0008. Then raise redirect (pc_sel=10, jal_target=0x4000_0040): request withdrawn, next fetched addr 0x4000_0040.
6. pc_q=0xFFFF_FFFC with sequential accept. Expect next addr 0x0000_0000 (wrap). Separately, rst pulsed mid-BUBBLE returns all outputs to reset values asynchronously.
